seq_detect_sched: RTL and testbench
===================================

# seq_detect_sched

Time-multiplexed scheduler that shares one overlapping "1011" serial pattern-detect function among NCH independent bit-stream requesters. A round-robin arbiter grants at most one channel per cycle. The block stores each channel's detector state (context) and applies the shared next-state function to the granted bit. It reports detections as a registered (channel, pulse) event and, optionally, keeps per-channel match counts. It sits between the serial front-end channels and the event/statistics logic.

## Interface
- NCH, 4, number of requesting channels (2..16)
- CNT_W, 8, width of per-channel saturating match counter
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- bit_valid  in  NCH  per-channel bit offered
- bit_data  in  NCH  per-channel serial bit
- bit_ready  out  NCH  one-hot-or-zero grant; bit accepted when valid&ready
- ch_en  in  NCH  channel enable; 0 = never granted, context forced to S0
- clr  in  1  synchronous clear of all contexts, counters, RR pointer
- det_valid  out  1  one-cycle detection pulse
- det_ch  out  $clog2(NCH)  channel of detection, valid with det_valid
- cnt_sel  in  $clog2(NCH)  counter read select
- cnt_out  out  CNT_W  match count of channel cnt_sel (combinational read)

## Operation
- Context states S0, S1, S10, S101, S1011. Transitions (din=0 / din=1):
  - S0: S0 / S1
  - S1: S10 / S1
  - S10: S0 / S101
  - S101: S10 / S1011
  - S1011: S10 / S1
- Detection = accepted bit moves a context into S1011. Matching overlaps: 1011011 yields two detects.
- Eligible channels: bit_valid[i] & ch_en[i].
- Grant: first eligible channel at or after rr_ptr, searching upward with wrap.
- bit_ready = one-hot of the granted channel; zero if no channel is eligible.
- After a grant to g: rr_ptr <= (g+1) mod NCH. No grant: rr_ptr unchanged.
- Accepted bit updates only ctx[g]. All other contexts hold.
- ch_en[i]=0: ctx[i] <= S0 every cycle. Counter holds. bit_ready[i]=0.
- clr and rst have equal effect:
  - all ctx <= S0, rr_ptr <= 0, counters <= 0
  - det_valid <= 0, det_ch <= 0
  - clr has priority over a same-cycle grant; that grant's bit is dropped and bit_ready is forced to 0 that cycle.
- Counter of the detecting channel increments by 1 and saturates at 2^CNT_W-1.
- Reset values: bit_ready=0 (no eligible channel during reset), det_valid=0, det_ch=0, cnt_out=0.

## Timing
- bit_ready is combinational from bit_valid, ch_en, rr_ptr and clr. There is no ready-to-valid dependency.
- Requesters must hold bit_valid/bit_data until accepted.
- Throughput: one bit per cycle aggregate. With all NCH channels continuously valid, each channel gets one bit per NCH cycles.
- Detect latency: det_valid/det_ch asserted the cycle after the edge accepting the final "1". det_valid is registered and high for exactly one cycle per detection.
- Consecutive cycles can carry detects from different channels, giving back-to-back det_valid.
- Counter update lands on the same edge that raises det_valid. cnt_out reflects it in that cycle.
- Reset or clr mid-sequence: partial patterns are lost. A detect pending from the accepting edge before reset is suppressed.

## Configuration
- SEQ_SCHED_CNT_EN:
  - Defined: per-channel counters and the cnt_out mux are built.
  - Undefined: counters are removed, cnt_out is tied to 0, cnt_sel is ignored.
  - Detection and arbitration are identical either way.

## Structure
- Package seq_det_pkg holds:
  - state_t enum (S0, S1, S10, S101, S1011; 3 bits)
  - function seq_next(state_t, logic), the shared next-state function
  - function seq_hit(state_t, logic), true on entry to S1011
- Sub-module rr_arbiter (parameter N):
  - inputs req[N], advance
  - outputs one-hot gnt[N], gnt_idx
  - holds the pointer internally
- Context array, detect register and counters live in the top.

## Test plan
- Single channel 0, ch_en=1, bits 1,0,1,1 → det_valid=1, det_ch=0 exactly one cycle after the 4th acceptance. cnt_out(sel 0)=1.
- Channel 2 stream 1,0,1,1,0,1,1 → two detect pulses, det_ch=2 both times. Channel 2 count=2.
- All 4 channels continuously valid → grant order 0,1,2,3,0,…. Channel 1 sends 1011 interleaved with other channels' noise → single detect, det_ch=1, 1 cycle after its 4th accepted bit.
- Channel 0 sends 1,0,1, then ch_en[0]=0 for one cycle, then 1 → no detect. Channel 0 not granted while disabled.
- Channel 3 sends 1,0,1; clr pulses in the cycle its final 1 is offered → bit not accepted, no detect, all counts 0, next grant starts from channel 0.
- CNT_W=2, channel 0 gets 5 matches → count reads 3 (saturated). Build without SEQ_SCHED_CNT_EN → cnt_out stays 0 with detects unchanged.

Source files
------------

// File: rtl/seq_det_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Package : seq_det_pkg
// Purpose : Shared types and the next-state function of the overlapping
//           "1011" serial detector used by seq_detect_sched.
// Contents: state_t  - detector context encoding (3 bits)
//           seq_next - next context for a given state and input bit
//           seq_hit  - true when the bit moves a context into S1011
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
package seq_det_pkg;

   typedef enum logic [2:0] {
      S0    = 3'd0,
      S1    = 3'd1,
      S10   = 3'd2,
      S101  = 3'd3,
      S1011 = 3'd4
   } state_t;

   function automatic state_t seq_next(input state_t s, input logic din);
      state_t n;
      case (s)
         S0:      n = din ? S1    : S0;
         S1:      n = din ? S1    : S10;
         S10:     n = din ? S101  : S0;
         S101:    n = din ? S1011 : S10;
         S1011:   n = din ? S1    : S10;
         default: n = S0;
      endcase
      return n;
   endfunction

   // Only S101 with a 1 enters S1011, so that is the whole hit condition.
   function automatic logic seq_hit(input state_t s, input logic din);
      return (s == S101) && din;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : rr_arbiter
// Purpose : Round-robin arbiter. Grants the first requester at or above the
//           internal pointer (with wrap); the pointer moves past the winner
//           when the grant is used.
// Ports   : clk, rst      - clock, synchronous active-high reset
//           clr           - synchronous clear of the pointer
//           req[N]        - requests
//           advance       - the current grant was consumed this cycle
//           gnt[N]        - one-hot (or zero) grant
//           gnt_idx       - index of the granted requester
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   logic [IW-1:0] r_ptr;
   logic          w_found;
   int            w_j;

   // Rotating priority search starting at r_ptr.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      w_found = 1'b0;
      w_j     = 0;
      for (int k = 0; k < N; k++) begin
         w_j = int'(r_ptr) + k;
         if (w_j >= N) w_j = w_j - N;
         if (!w_found && req[w_j]) begin
            w_found  = 1'b1;
            gnt[w_j] = 1'b1;
            gnt_idx  = IW'(w_j);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_ptr <= '0;
      end else if (advance) begin
         r_ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/seq_detect_sched.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : seq_detect_sched
// Purpose : Shares one overlapping "1011" detector among NCH bit-stream
//           channels. A round-robin arbiter accepts at most one bit per cycle;
//           per-channel detector contexts are stored here and updated with
//           the shared next-state function. Detections are reported as a
//           registered (det_valid, det_ch) pulse.
// Option  : SEQ_SCHED_CNT_EN - when defined, per-channel saturating match
//           counters and the cnt_out read mux are built; otherwise cnt_out
//           is 0 and cnt_sel is ignored.
// Ports   : clk, rst          - clock, synchronous active-high reset
//           bit_valid/bit_data - per-channel offered bit
//           bit_ready         - one-hot-or-zero grant (combinational)
//           ch_en             - channel enable (disabled => context S0)
//           clr               - synchronous clear (same effect as rst)
//           det_valid, det_ch - one-cycle detection event
//           cnt_sel, cnt_out  - combinational counter read port
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module seq_detect_sched
   import seq_det_pkg::*;
#(
   parameter  int NCH   = 4,
   parameter  int CNT_W = 8,
   localparam int CH_W  = $clog2(NCH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NCH-1:0]   bit_valid,
   input  logic [NCH-1:0]   bit_data,
   output logic [NCH-1:0]   bit_ready,
   input  logic [NCH-1:0]   ch_en,
   input  logic             clr,
   output logic             det_valid,
   output logic [CH_W-1:0]  det_ch,
   input  logic [CH_W-1:0]  cnt_sel,
   output logic [CNT_W-1:0] cnt_out
);

   logic [NCH-1:0]  w_req;
   logic [NCH-1:0]  w_gnt;
   logic [CH_W-1:0] w_gidx;
   logic            w_accept;
   logic            w_hit;
   state_t          w_gstate;
   logic            w_gbit;

   state_t          r_ctx [NCH];
   logic            r_det_valid;
   logic [CH_W-1:0] r_det_ch;

   assign w_req = bit_valid & ch_en;

   // clr wins over a same-cycle grant: the bit is simply not accepted.
   assign bit_ready = clr ? '0 : w_gnt;
   assign w_accept  = |bit_ready;

   rr_arbiter #(.N(NCH)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .req     (w_req),
      .advance (w_accept),
      .gnt     (w_gnt),
      .gnt_idx (w_gidx)
   );

   assign w_gstate = r_ctx[w_gidx];
   assign w_gbit   = bit_data[w_gidx];
   assign w_hit    = w_accept && seq_hit(w_gstate, w_gbit);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         for (int i = 0; i < NCH; i++) r_ctx[i] <= S0;
         r_det_valid <= 1'b0;
         r_det_ch    <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (!ch_en[i])
               r_ctx[i] <= S0;
            else if (bit_ready[i])
               r_ctx[i] <= seq_next(r_ctx[i], bit_data[i]);
         end
         r_det_valid <= w_hit;
         if (w_hit) r_det_ch <= w_gidx;
      end
   end

   assign det_valid = r_det_valid;
   assign det_ch    = r_det_ch;

`ifdef SEQ_SCHED_CNT_EN
   logic [CNT_W-1:0] r_cnt [NCH];

   // Counter moves on the same edge that raises det_valid.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         for (int i = 0; i < NCH; i++) r_cnt[i] <= '0;
      end else if (w_hit && (r_cnt[w_gidx] != {CNT_W{1'b1}})) begin
         r_cnt[w_gidx] <= r_cnt[w_gidx] + 1'b1;
      end
   end

   always_comb begin
      cnt_out = '0;
      for (int i = 0; i < NCH; i++)
         if (cnt_sel == CH_W'(i)) cnt_out = r_cnt[i];
   end
`else
   logic w_unused_cnt_sel;
   assign w_unused_cnt_sel = ^cnt_sel;
   assign cnt_out          = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_sched.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_seq_detect_sched
// Purpose : Directed, scoreboard-checked bench for seq_detect_sched
//           (NCH=4, CNT_W=2). Expected detections are queued by the
//           stimulus with their arrival cycle; a monitor pops them whenever
//           det_valid is seen. Counter expectations follow SEQ_SCHED_CNT_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_seq_detect_sched;

   localparam int NCH   = 4;
   localparam int CNT_W = 2;
   localparam int CH_W  = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [NCH-1:0]   bit_valid;
   logic [NCH-1:0]   bit_data;
   logic [NCH-1:0]   bit_ready;
   logic [NCH-1:0]   ch_en;
   logic             clr;
   logic             det_valid;
   logic [CH_W-1:0]  det_ch;
   logic [CH_W-1:0]  cnt_sel;
   logic [CNT_W-1:0] cnt_out;

   typedef struct {
      int ch;
      int cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   seq_detect_sched #(.NCH(NCH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .bit_valid (bit_valid),
      .bit_data  (bit_data),
      .bit_ready (bit_ready),
      .ch_en     (ch_en),
      .clr       (clr),
      .det_valid (det_valid),
      .det_ch    (det_ch),
      .cnt_sel   (cnt_sel),
      .cnt_out   (cnt_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every detect pulse must match the head of the expected queue.
   always @(negedge clk) begin
      if (!rst && det_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL det_unexpected: got ch=%0d at cyc=%0d, required no detect", det_ch, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (int'(det_ch) != e.ch || cyc != e.cyc) begin
               errors++;
               $display("FAIL det_event: got ch=%0d cyc=%0d, required ch=%0d cyc=%0d",
                        det_ch, cyc, e.ch, e.cyc);
            end
         end
      end
   end

   function automatic int expc(input int n);
`ifdef SEQ_SCHED_CNT_EN
      return n;
`else
      return 0 * n;
`endif
   endfunction

   task automatic check(input string name, input int got, input int req);
      checks++;
      if (got != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, got, req);
      end
   endtask

   task automatic check_cnt(input int sel, input int req);
      cnt_sel = CH_W'(sel);
      #1;
      check($sformatf("cnt_out[%0d]", sel), int'(cnt_out), expc(req));
   endtask

   // Offer one bit on ch until it is granted; queue a detect if it completes 1011.
   task automatic send(input int ch, input logic b, input bit hit);
      bit done;
      done = 1'b0;
      bit_valid[ch] = 1'b1;
      bit_data[ch]  = b;
      for (int t = 0; t < 20 && !done; t++) begin
         #1;
         if (bit_ready[ch]) begin
            done = 1'b1;
            if (hit) exp_q.push_back('{ch, cyc + 1});
         end
         @(negedge clk);
      end
      bit_valid[ch] = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL send_grant ch=%0d: got no grant in 20 cycles, required grant", ch);
      end
   endtask

   logic d3 [4][4];
   int   idx [4];
   logic [7:0]  s7;
   logic [15:0] s16;

   initial begin
      rst = 1'b1; clr = 1'b0; bit_valid = '0; bit_data = '0; ch_en = '0; cnt_sel = '0;
      @(negedge clk); @(negedge clk);
      #1;
      check("reset bit_ready", int'(bit_ready), 0);
      check("reset det_valid", int'(det_valid), 0);
      check("reset det_ch",    int'(det_ch),    0);
      check("reset cnt_out",   int'(cnt_out),   0);
      @(negedge clk);
      rst = 1'b0;
      ch_en = 4'hF;

      // Channel 0: 1011 -> one detect
      send(0, 1'b1, 0); send(0, 1'b0, 0); send(0, 1'b1, 0); send(0, 1'b1, 1);
      check_cnt(0, 1);

      // Channel 2: 1011011 -> two overlapping detects
      s7 = 8'b0110_1101;   // bits sent LSB first: 1,0,1,1,0,1,1
      for (int i = 0; i < 7; i++) send(2, s7[i], (i == 3) || (i == 6));
      check_cnt(2, 2);

      // Clear, then all four channels valid: strict 0,1,2,3 rotation
      clr = 1'b1; @(negedge clk); clr = 1'b0;
      check_cnt(2, 0);
      d3 = '{'{1'b0, 1'b0, 1'b0, 1'b0},
             '{1'b1, 1'b0, 1'b1, 1'b1},
             '{1'b1, 1'b1, 1'b1, 1'b1},
             '{1'b1, 1'b0, 1'b1, 1'b0}};
      idx = '{0, 0, 0, 0};
      bit_valid = 4'hF;
      for (int step = 0; step < 16; step++) begin
         for (int c = 0; c < 4; c++) bit_data[c] = d3[c][(idx[c] < 4) ? idx[c] : 3];
         #1;
         check($sformatf("rr_grant step%0d", step), int'(bit_ready), 1 << (step % 4));
         if ((step % 4) == 1 && idx[1] == 3) exp_q.push_back('{1, cyc + 1});
         idx[step % 4]++;
         @(negedge clk);
      end
      bit_valid = '0;
      check_cnt(1, 1);

      // Channel 0: 1,0,1, disabled for one cycle, then 1 -> no detect
      send(0, 1'b1, 0); send(0, 1'b0, 0); send(0, 1'b1, 0);
      bit_valid[0] = 1'b1; bit_data[0] = 1'b1; ch_en[0] = 1'b0;
      #1;
      check("disabled ch0 ready", int'(bit_ready), 0);
      @(negedge clk);
      ch_en[0] = 1'b1;
      send(0, 1'b1, 0);                        // context restarted: S1, no hit
      send(0, 1'b0, 0); send(0, 1'b1, 0); send(0, 1'b1, 1);
      check_cnt(0, 1);

      // Channel 3: 1,0,1 then clr while final 1 is offered
      send(3, 1'b1, 0); send(3, 1'b0, 0); send(3, 1'b1, 0);
      bit_valid[3] = 1'b1; bit_data[3] = 1'b1; clr = 1'b1;
      #1;
      check("clr forces ready 0", int'(bit_ready), 0);
      @(negedge clk);
      clr = 1'b0; bit_valid = '0;
      for (int s = 0; s < 4; s++) check_cnt(s, 0);
      bit_valid = 4'hF; bit_data = '0;
      #1;
      check("grant after clr", int'(bit_ready), 1);
      @(negedge clk);
      bit_valid = '0;

      // Channel 0: 1011011011011011 -> five detects, counter saturates at 3
      s16 = 16'b1101_1011_0110_1101;
      for (int i = 0; i < 16; i++) begin
         send(0, s16[i], (i == 3) || (i == 6) || (i == 9) || (i == 12) || (i == 15));
         if (i == 6) check_cnt(0, 2);
      end
      check_cnt(0, 3);

      repeat (3) @(negedge clk);
      check("pending detects", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
